// File: rtl/core_bridge_pkg.sv
// Shared constants for the bridge host-command protocol: magic words,
// register window offsets, command codes and the host state encoding.
package core_bridge_pkg;

  localparam logic [15:0] MAGIC_CM = 16'h434D;
  localparam logic [15:0] MAGIC_BU = 16'h4255;
  localparam logic [15:0] MAGIC_OK = 16'h4F4B;

  localparam logic [31:0] OFS_CMD   = 32'h0000_0000;
  localparam logic [31:0] OFS_PARAM = 32'h0000_0020;
  localparam logic [31:0] OFS_RESP  = 32'h0000_0040;

  localparam logic [15:0] CMD_STATUS      = 16'h0000;
  localparam logic [15:0] CMD_RESET_ENTER = 16'h0010;
  localparam logic [15:0] CMD_RESET_EXIT  = 16'h0011;
  localparam logic [15:0] CMD_DS_COMPLETE = 16'h008A;
  localparam logic [15:0] CMD_RTC         = 16'h00B0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PARAM,
    S_WR_CMD,
    S_POLL_GAP,
    S_POLL_RD,
    S_POLL_WAIT,
    S_RD_RESP,
    S_DONE
  } host_state_t;

endpackage

// File: rtl/bridge_byteswap32.sv
// 32-bit byte-order reversal with bypass; used on both bus data directions.
module bridge_byteswap32 (
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = en ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;

endmodule

// File: rtl/core_bridge_host_cmd.sv
// Host-side initiator for the bridge host-command protocol: writes params and
// command, polls status, reads responses. BRIDGE_HOST_LITTLE_ENDIAN_EN selects a byte-swapped bus.
module core_bridge_host_cmd
  import core_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'hF8000000,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [15:0]  i_cmd,
  input  logic [127:0] i_param,
  output logic         o_busy,
  output logic         o_done,
  output logic [15:0]  o_result,
  output logic [127:0] o_resp,
  output logic         o_timeout,
  output logic         o_proterr,
  output logic         bridge_endian_little,
  output logic [31:0]  bridge_addr,
  output logic         bridge_wr,
  output logic [31:0]  bridge_wr_data,
  output logic         bridge_rd,
  input  logic [31:0]  bridge_rd_data
);

`ifdef BRIDGE_HOST_LITTLE_ENDIAN_EN
  localparam logic       ENDIAN_LE  = 1'b1;
  localparam logic [2:0] SETTLE_CYC = 3'd4;
`else
  localparam logic       ENDIAN_LE  = 1'b0;
  localparam logic [2:0] SETTLE_CYC = 3'd0;
`endif

  localparam logic [2:0]  LAT = 3'(RD_LATENCY);
  localparam logic [15:0] GAP = 16'(POLL_GAP);

  host_state_t  state;
  logic [2:0]   settle_cnt;
  logic         settled;
  logic [1:0]   idx;
  logic [15:0]  gap_cnt;
  logic [15:0]  poll_cnt;
  logic [2:0]   lat_cnt;
  logic         rsp_wait;
  logic         fin_to;
  logic         fin_pe;
  logic         start_ok;
  logic [31:0]  wr_data_q;
  logic [31:0]  rd_word;
  logic [15:0]  cmd_q;
  logic [127:0] param_q;
  logic [15:0]  result_buf;
  logic [127:0] resp_buf;

  assign bridge_endian_little = ENDIAN_LE;
  assign settled  = (settle_cnt == SETTLE_CYC);
  // A start coinciding with the o_done pulse is not taken.
  assign start_ok = (state == S_IDLE) && i_start && !o_done;

  bridge_byteswap32 u_swap_wr (
    .en   (ENDIAN_LE),
    .din  (wr_data_q),
    .dout (bridge_wr_data)
  );

  bridge_byteswap32 u_swap_rd (
    .en   (ENDIAN_LE),
    .din  (bridge_rd_data),
    .dout (rd_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      settle_cnt  <= 3'd0;
      idx         <= 2'd0;
      gap_cnt     <= 16'd0;
      poll_cnt    <= 16'd0;
      lat_cnt     <= 3'd0;
      rsp_wait    <= 1'b0;
      fin_to      <= 1'b0;
      fin_pe      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_result    <= 16'd0;
      o_resp      <= 128'd0;
      o_timeout   <= 1'b0;
      o_proterr   <= 1'b0;
      bridge_addr <= 32'd0;
      bridge_wr   <= 1'b0;
      bridge_rd   <= 1'b0;
      wr_data_q   <= 32'd0;
    end else begin
      bridge_wr <= 1'b0;
      bridge_rd <= 1'b0;
      o_done    <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 3'd1;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            o_busy   <= 1'b1;
            idx      <= 2'd0;
            poll_cnt <= 16'd0;
            fin_to   <= 1'b0;
            fin_pe   <= 1'b0;
            state    <= S_WR_PARAM;
          end
        end
        // Bus accesses stall here until the responder's endian sync has settled.
        S_WR_PARAM: begin
          if (settled) begin
            bridge_wr   <= 1'b1;
            bridge_addr <= BASE_ADDR + OFS_PARAM + {28'd0, idx, 2'b00};
            wr_data_q   <= param_q[{idx, 5'd0} +: 32];
            idx         <= idx + 2'd1;
            if (idx == 2'd3) state <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          bridge_wr   <= 1'b1;
          bridge_addr <= BASE_ADDR + OFS_CMD;
          wr_data_q   <= {MAGIC_CM, cmd_q};
          gap_cnt     <= GAP;
          state       <= S_POLL_GAP;
        end
        S_POLL_GAP: begin
          if (gap_cnt == 16'd0) state <= S_POLL_RD;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        S_POLL_RD: begin
          bridge_rd   <= 1'b1;
          bridge_addr <= BASE_ADDR + OFS_CMD;
          if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
          lat_cnt     <= 3'd0;
          state       <= S_POLL_WAIT;
        end
        // Status is decoded on the cycle the read data becomes valid.
        S_POLL_WAIT: begin
          if (lat_cnt != LAT) begin
            lat_cnt <= lat_cnt + 3'd1;
          end else if (rd_word[31:16] == MAGIC_OK) begin
            idx      <= 2'd0;
            rsp_wait <= 1'b0;
            state    <= S_RD_RESP;
          end else if (rd_word[31:16] == MAGIC_CM || rd_word[31:16] == MAGIC_BU) begin
            if (32'(poll_cnt) >= TIMEOUT_POLLS) begin
              fin_to <= 1'b1;
              state  <= S_DONE;
            end else begin
              gap_cnt <= GAP;
              state   <= S_POLL_GAP;
            end
          end else begin
            fin_pe <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_RD_RESP: begin
          if (!rsp_wait) begin
            bridge_rd   <= 1'b1;
            bridge_addr <= BASE_ADDR + OFS_RESP + {28'd0, idx, 2'b00};
            lat_cnt     <= 3'd0;
            rsp_wait    <= 1'b1;
          end else if (lat_cnt != LAT) begin
            lat_cnt <= lat_cnt + 3'd1;
          end else begin
            rsp_wait <= 1'b0;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) state <= S_DONE;
          end
        end
        S_DONE: begin
          o_done    <= 1'b1;
          o_busy    <= 1'b0;
          o_timeout <= fin_to;
          o_proterr <= fin_pe;
          if (fin_to || fin_pe) begin
            o_result <= 16'hFFFF;
          end else begin
            o_result <= result_buf;
            o_resp   <= resp_buf;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command payload and read-back buffers carry no reset; they are only
  // consumed after being written within the same command.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      cmd_q   <= i_cmd;
      param_q <= i_param;
    end
    if (state == S_POLL_WAIT && lat_cnt == LAT && rd_word[31:16] == MAGIC_OK)
      result_buf <= rd_word[15:0];
    if (state == S_RD_RESP && rsp_wait && lat_cnt == LAT)
      resp_buf[{idx, 5'd0} +: 32] <= rd_word;
  end

endmodule

// File: tb/tb_core_bridge_host_cmd.sv
// Bench for core_bridge_host_cmd: behavioural command-handler responder plus
// a per-command expectation queue checked on every o_done.
module tb_core_bridge_host_cmd;
  import core_bridge_pkg::*;

  localparam logic [31:0] BASE   = 32'hF8000000;
  localparam int          RDL    = 2;
  localparam int          GAP    = 4;
  localparam int          TPOLLS = 8;
`ifdef BRIDGE_HOST_LITTLE_ENDIAN_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_start = 1'b0;
  logic [15:0]  i_cmd = 16'd0;
  logic [127:0] i_param = 128'd0;
  logic         o_busy, o_done, o_timeout, o_proterr;
  logic [15:0]  o_result;
  logic [127:0] o_resp;
  logic         bridge_endian_little, bridge_wr, bridge_rd;
  logic [31:0]  bridge_addr, bridge_wr_data, bridge_rd_data;

  core_bridge_host_cmd #(
    .BASE_ADDR(BASE), .RD_LATENCY(RDL), .POLL_GAP(GAP), .TIMEOUT_POLLS(TPOLLS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_cmd(i_cmd), .i_param(i_param),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_resp(o_resp),
    .o_timeout(o_timeout), .o_proterr(o_proterr),
    .bridge_endian_little(bridge_endian_little), .bridge_addr(bridge_addr),
    .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
    .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sw(input logic [31:0] w);
    return LE ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  function automatic logic [15:0] model_res(input logic [15:0] c);
    case (c)
      CMD_STATUS:     return 16'h0003;
      CMD_RESET_EXIT: return 16'h0000;
      default:        return 16'hFFFF;
    endcase
  endfunction

  // Responder: mode 0 = command handler, 1 = always busy, 2 = garbage status
  int          mode = 0;
  int          busy_cfg = 0;
  logic [31:0] resp_words [4] = '{default: 32'h0};
  int          n_wr = 0, n_stat = 0, n_resp = 0;
  logic [31:0] seen_param [4] = '{default: 32'h0};
  logic        core_rst_n = 1'b0;
  int          busy_left = 0;
  logic [15:0] hres = 16'h0;
  logic [31:0] rd_pipe [RDL] = '{default: 32'h0};
  logic [31:0] rsp_off, rsp_wword, rsp_rword;

  assign rsp_off   = bridge_addr - BASE;
  assign rsp_wword = sw(bridge_wr_data);
  assign bridge_rd_data = rd_pipe[RDL-1];

  always_comb begin
    rsp_rword = 32'hBAD0BAD0;
    if (rsp_off == 32'h0) begin
      if (mode == 1)          rsp_rword = 32'h42550000;
      else if (mode == 2)     rsp_rword = 32'hDEAD0000;
      else if (busy_left > 0) rsp_rword = {MAGIC_BU, 16'h0000};
      else                    rsp_rword = {MAGIC_OK, hres};
    end else if (rsp_off >= 32'h40 && rsp_off <= 32'h4C) begin
      rsp_rword = resp_words[rsp_off[3:2]];
    end
  end

  always @(posedge clk) begin
    if (!reset_n) core_rst_n <= 1'b0;
    if (bridge_wr) begin
      n_wr <= n_wr + 1;
      if (rsp_off >= 32'h20 && rsp_off <= 32'h2C) seen_param[rsp_off[3:2]] <= rsp_wword;
      if (rsp_off == 32'h0 && rsp_wword[31:16] == MAGIC_CM) begin
        busy_left <= busy_cfg;
        case (rsp_wword[15:0])
          CMD_STATUS:     hres <= 16'h0003;
          CMD_RESET_EXIT: begin hres <= 16'h0000; core_rst_n <= 1'b1; end
          default:        hres <= 16'hFFFF;
        endcase
      end
    end
    rd_pipe[0] <= 32'h0;
    if (bridge_rd) begin
      if (rsp_off == 32'h0) begin
        n_stat <= n_stat + 1;
        if (mode == 0 && busy_left > 0) busy_left <= busy_left - 1;
      end else if (rsp_off >= 32'h40 && rsp_off <= 32'h4C) begin
        n_resp <= n_resp + 1;
      end
      rd_pipe[0] <= sw(rsp_rword);
    end
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct {
    logic [15:0]  res;
    logic [127:0] resp;
    bit           to;
    bit           pe;
  } exp_t;

  exp_t         expq[$];
  int           checks = 0, errors = 0, done_seen = 0;
  logic [127:0] last_resp = 128'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every bench cycle goes through here so the compare runs on each cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      chk("wr_rd_exclusive", 128'(bridge_wr & bridge_rd), 128'(1'b0));
      if (o_done) begin
        done_seen++;
        chk("busy_at_done", 128'(o_busy), 128'(1'b0));
        if (expq.size() == 0) begin
          chk("unexpected_done", 128'(o_done), 128'(1'b0));
        end else begin
          e = expq.pop_front();
          chk("result", 128'(o_result), 128'(e.res));
          chk("resp", o_resp, e.resp);
          chk("timeout_flag", 128'(o_timeout), 128'(e.to));
          chk("proterr_flag", 128'(o_proterr), 128'(e.pe));
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [15:0] cmd, input logic [127:0] prm, input int m,
                         input int b, input bit extra_start,
                         output logic [15:0] res, output logic to, output logic pe);
    exp_t e;
    int   w0, s0, r0, d0, nstat_exp;
    bit   ok;
    mode = m;
    busy_cfg = b;
    for (int i = 0; i < 4; i++) resp_words[i] = $urandom();
    ok     = (m == 0);
    e.to   = (m == 1);
    e.pe   = (m == 2);
    e.res  = ok ? model_res(cmd) : 16'hFFFF;
    e.resp = ok ? {resp_words[3], resp_words[2], resp_words[1], resp_words[0]} : last_resp;
    if (ok) last_resp = e.resp;
    nstat_exp = (m == 0) ? b + 1 : (m == 1) ? TPOLLS : 1;
    expq.push_back(e);
    w0 = n_wr; s0 = n_stat; r0 = n_resp; d0 = done_seen;
    i_cmd = cmd; i_param = prm; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", 128'(o_busy), 128'(1'b1));
    for (int c = 0; c < 3000 && done_seen == d0; c++) begin
      if (extra_start && c == 3) begin
        i_cmd = CMD_RESET_EXIT;
        i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      tick();
    end
    i_start = 1'b0;
    if (done_seen == d0) begin
      chk("done_wait", 128'(done_seen), 128'(d0 + 1));
      expq.delete();
    end
    res = o_result; to = o_timeout; pe = o_proterr;
    chk("wr_count", 128'(n_wr - w0), 128'(5));
    chk("status_reads", 128'(n_stat - s0), 128'(nstat_exp));
    chk("resp_reads", 128'(n_resp - r0), 128'(ok ? 4 : 0));
    chk("params_seen", {seen_param[3], seen_param[2], seen_param[1], seen_param[0]}, prm);
    if (ok && cmd == CMD_RESET_EXIT) chk("core_reset_released", 128'(core_rst_n), 128'(1'b1));
    tick();
  endtask

  initial begin
    logic [15:0]  res;
    logic         to, pe;
    logic [31:0]  held_addr;
    int           w_hold, found;
    logic [15:0]  rc;
    int           rm, pick;

    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", 128'({o_busy, o_done, o_timeout, o_proterr, bridge_wr, bridge_rd}), 128'(6'd0));
    chk("rst_result", 128'(o_result), 128'(16'h0));
    chk("rst_resp", o_resp, 128'd0);
    chk("rst_bus", 128'({bridge_addr, bridge_wr_data}), 128'(64'd0));
    chk("endian_flag", 128'(bridge_endian_little), 128'(LE));
    reset_n = 1'b1;
    repeat (2) tick();

    chk("core_reset_held", 128'(core_rst_n), 128'(1'b0));
    run_cmd(CMD_RESET_EXIT, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 1'b0, res, to, pe);
    chk("reset_exit_result", 128'(res), 128'(16'h0000));

    run_cmd(CMD_STATUS, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 2, 1'b0, res, to, pe);
    chk("status_result", 128'(res), 128'(16'h0003));
    chk("status_flags", 128'({to, pe}), 128'(2'b00));

    run_cmd(16'h1234, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 1'b0, res, to, pe);
    chk("unknown_result", 128'(res), 128'(16'hFFFF));
    chk("unknown_proterr", 128'(pe), 128'(1'b0));

    run_cmd(CMD_STATUS, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 0, 1'b0, res, to, pe);
    chk("timeout_set", 128'(to), 128'(1'b1));
    chk("timeout_result", 128'(res), 128'(16'hFFFF));

    run_cmd(CMD_RTC, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, 1'b1, res, to, pe);
    chk("proterr_set", 128'(pe), 128'(1'b1));
    chk("proterr_result", 128'(res), 128'(16'hFFFF));
    held_addr = bridge_addr;
    w_hold = n_wr;
    repeat (20) tick();
    chk("addr_hold_idle", 128'(bridge_addr), 128'(held_addr));
    chk("no_second_cmd", 128'(n_wr), 128'(w_hold));

    for (int k = 0; k < 12; k++) begin
      pick = $urandom_range(0, 3);
      rc = (pick == 0) ? CMD_STATUS : (pick == 1) ? CMD_RESET_EXIT :
           (pick == 2) ? CMD_DS_COMPLETE : 16'($urandom());
      pick = $urandom_range(0, 9);
      rm = (pick == 0) ? 2 : (pick == 1) ? 1 : 0;
      run_cmd(rc, {$urandom(), $urandom(), $urandom(), $urandom()}, rm,
              $urandom_range(0, 3), 1'b0, res, to, pe);
    end

    // Reset in the middle of a status read must abort silently.
    mode = 0;
    busy_cfg = 3;
    i_cmd = CMD_STATUS;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      tick();
      if (bridge_rd && bridge_addr == BASE) found = 1;
    end
    chk("reached_poll_wait", 128'(found), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobes", 128'({bridge_wr, bridge_rd}), 128'(2'b00));
    chk("abort_busy", 128'(o_busy), 128'(1'b0));
    repeat (3) tick();
    reset_n = 1'b1;
    last_resp = 128'd0;
    chk("post_abort_result", 128'(o_result), 128'(16'h0));
    chk("post_abort_resp", o_resp, 128'd0);
    repeat (5) tick();
    run_cmd(CMD_STATUS, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 1'b0, res, to, pe);
    chk("post_abort_status", 128'(res), 128'(16'h0003));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
